// File: rtl/enemy_wave_controller.sv
// Enemy formation engine: spawns a V-shaped wave, advances it on a movement tick,
// and tracks kills and escapes until the wave is gone.
module enemy_wave_controller #(
  parameter int unsigned N_ENEMY     = 17,
  parameter int unsigned X_ORIGIN    = 16,
  parameter int unsigned X_SPACING   = 38,
  parameter int unsigned Y_STAGGER   = 4,
  parameter int unsigned TICK_PERIOD = 32768,
  parameter int unsigned DY          = 2,
  parameter int unsigned ZIG_STEP    = 2,
  parameter int unsigned ZIG_AMP     = 16,
  parameter int unsigned Y_LIMIT     = 448
) (
  input  logic                  clk25,
  input  logic                  reset_fly,
  input  logic                  start,
  input  logic [1:0]            mode,
  input  logic                  kill_valid,
  input  logic [4:0]            kill_idx,
  output logic [10*N_ENEMY-1:0] enemy_x,
  output logic [10*N_ENEMY-1:0] enemy_y,
  output logic [N_ENEMY-1:0]    enemy_alive,
  output logic                  wave_active,
  output logic                  wave_cleared,
  output logic [5:0]            kill_count,
  output logic [5:0]            escape_count,
  output logic [7:0]            wave_num
);

  localparam int unsigned CntW = $clog2(TICK_PERIOD);
  localparam logic signed [9:0] ZigStep = 10'(ZIG_STEP);
  localparam logic signed [9:0] ZigAmp  = 10'(ZIG_AMP);

  typedef enum logic [1:0] {StIdle, StSpawn, StRun, StDone} state_e;

  state_e              state_q;
  logic [9:0]          x_q [N_ENEMY];
  logic [9:0]          y_q [N_ENEMY];
  logic [N_ENEMY-1:0]  alive_q;
  logic [5:0]          kill_cnt_q, esc_cnt_q;
  logic [7:0]          wave_num_q;
  logic [CntW-1:0]     tick_cnt_q;
  logic signed [9:0]   zig_off_q;
  logic                zig_dir_q;  // 0 = moving right
  logic                wave_active_q, wave_cleared_q;

  logic                tick, move, zig, zig_flip;
  logic signed [9:0]   zig_nz;
  logic [N_ENEMY-1:0]  kill_mask, esc_mask;
  logic [6:0]          esc_num, esc_sum;
  logic [5:0]          esc_sat;

  assign tick     = (state_q == StRun) && (tick_cnt_q == CntW'(TICK_PERIOD - 1));
  assign move     = tick && !mode[1];
  assign zig      = tick && (mode == 2'd1);
  assign zig_nz   = zig_dir_q ? zig_off_q - ZigStep : zig_off_q + ZigStep;
  assign zig_flip = (zig_nz == ZigAmp) || (zig_nz == -ZigAmp);

  // A kill on an escaping enemy suppresses the escape so it is counted once.
  always_comb begin
    kill_mask = '0;
    esc_mask  = '0;
    esc_num   = '0;
    for (int i = 0; i < int'(N_ENEMY); i++) begin
      kill_mask[i] = kill_valid && (state_q == StRun) && (kill_idx == 5'(i)) && alive_q[i];
      esc_mask[i]  = move && alive_q[i] && (y_q[i] >= 10'(Y_LIMIT)) && !kill_mask[i];
      esc_num      = esc_num + 7'(esc_mask[i]);
    end
    esc_sum = 7'(esc_cnt_q) + esc_num;
    esc_sat = (esc_sum > 7'd63) ? 6'd63 : esc_sum[5:0];
  end

  always_ff @(posedge clk25 or posedge reset_fly) begin
    if (reset_fly) begin
      state_q        <= StIdle;
      for (int i = 0; i < int'(N_ENEMY); i++) begin
        x_q[i] <= '0;
        y_q[i] <= '0;
      end
      alive_q        <= '0;
      kill_cnt_q     <= '0;
      esc_cnt_q      <= '0;
      wave_num_q     <= '0;
      tick_cnt_q     <= '0;
      zig_off_q      <= '0;
      zig_dir_q      <= 1'b0;
      wave_active_q  <= 1'b0;
      wave_cleared_q <= 1'b0;
    end else begin
      wave_cleared_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q       <= StSpawn;
            wave_active_q <= 1'b1;
          end
        end
        StSpawn: begin
          for (int i = 0; i < int'(N_ENEMY); i++) begin
            x_q[i] <= 10'(X_ORIGIN + i * X_SPACING);
            if (i <= int'((N_ENEMY - 1) / 2)) y_q[i] <= 10'(i * Y_STAGGER);
            else                              y_q[i] <= 10'((N_ENEMY - 1 - i) * Y_STAGGER);
          end
          alive_q    <= '1;
          kill_cnt_q <= '0;
          esc_cnt_q  <= '0;
          zig_off_q  <= '0;
          zig_dir_q  <= 1'b0;
          tick_cnt_q <= '0;
          wave_num_q <= wave_num_q + 8'd1;
          state_q    <= StRun;
        end
        StRun: begin
          if (alive_q == '0) begin
            state_q        <= StDone;
            wave_active_q  <= 1'b0;
            wave_cleared_q <= 1'b1;
          end else begin
            tick_cnt_q <= tick ? '0 : tick_cnt_q + CntW'(1);
            alive_q    <= alive_q & ~kill_mask & ~esc_mask;
            esc_cnt_q  <= esc_sat;
            if ((|kill_mask) && (kill_cnt_q != 6'd63)) kill_cnt_q <= kill_cnt_q + 6'd1;
            if (move) begin
              for (int i = 0; i < int'(N_ENEMY); i++) begin
                if (alive_q[i] && (y_q[i] < 10'(Y_LIMIT))) y_q[i] <= y_q[i] + 10'(DY);
              end
            end
            // Zigzag shifts every enemy, dead or alive, so the formation stays rigid.
            if (zig) begin
              for (int i = 0; i < int'(N_ENEMY); i++) begin
                x_q[i] <= zig_dir_q ? x_q[i] - 10'(ZIG_STEP) : x_q[i] + 10'(ZIG_STEP);
              end
              zig_off_q <= zig_nz;
              if (zig_flip) zig_dir_q <= ~zig_dir_q;
            end
          end
        end
        StDone: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    enemy_x = '0;
    enemy_y = '0;
    for (int i = 0; i < int'(N_ENEMY); i++) begin
      enemy_x[10*i +: 10] = x_q[i];
      enemy_y[10*i +: 10] = y_q[i];
    end
  end

  assign enemy_alive  = alive_q;
  assign wave_active  = wave_active_q;
  assign wave_cleared = wave_cleared_q;
  assign kill_count   = kill_cnt_q;
  assign escape_count = esc_cnt_q;
  assign wave_num     = wave_num_q;

endmodule

// File: tb/tb_enemy_wave_controller.sv
// Directed bench for enemy_wave_controller with a 4-cycle movement tick.
module tb_enemy_wave_controller;
  localparam int N = 17;

  logic            clk25 = 1'b0;
  logic            reset_fly, start, kill_valid;
  logic [1:0]      mode;
  logic [4:0]      kill_idx;
  logic [10*N-1:0] enemy_x, enemy_y;
  logic [N-1:0]    enemy_alive;
  logic            wave_active, wave_cleared;
  logic [5:0]      kill_count, escape_count;
  logic [7:0]      wave_num;

  int total = 0;
  int bad   = 0;

  always #5 clk25 = ~clk25;

  enemy_wave_controller #(.N_ENEMY(N), .TICK_PERIOD(4)) dut (
    .clk25(clk25), .reset_fly(reset_fly), .start(start), .mode(mode),
    .kill_valid(kill_valid), .kill_idx(kill_idx), .enemy_x(enemy_x), .enemy_y(enemy_y),
    .enemy_alive(enemy_alive), .wave_active(wave_active), .wave_cleared(wave_cleared),
    .kill_count(kill_count), .escape_count(escape_count), .wave_num(wave_num)
  );

  function automatic logic [9:0] ex(int i);
    return enemy_x[10*i +: 10];
  endfunction

  function automatic logic [9:0] ey(int i);
    return enemy_y[10*i +: 10];
  endfunction

  task automatic ticks(int k);
    repeat (4 * k) @(negedge clk25);
  endtask

  // Start pulse, then land on the first RUN cycle (tick counter at 0).
  task automatic spawn_wave();
    start = 1'b1;
    @(negedge clk25);
    start = 1'b0;
    total++; if (wave_active !== 1'b1) begin bad++; $display("FAIL spawn_active got %0b want 1", wave_active); end
    @(negedge clk25);
  endtask

  task automatic wait_clear(input logic [5:0] want_kill, input logic [5:0] want_esc);
    bit found = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk25);
      if (wave_cleared) begin found = 1; break; end
    end
    total++; if (!found) begin bad++; $display("FAIL clear_timeout got 0 want 1"); end
    total++; if (kill_count !== want_kill) begin bad++; $display("FAIL clear_kills got %0d want %0d", kill_count, want_kill); end
    total++; if (escape_count !== want_esc) begin bad++; $display("FAIL clear_escapes got %0d want %0d", escape_count, want_esc); end
    total++; if (enemy_alive !== 17'h0) begin bad++; $display("FAIL clear_alive got %h want 0", enemy_alive); end
    @(negedge clk25);
    total++; if (wave_cleared !== 1'b0) begin bad++; $display("FAIL clear_pulse_width got %0b want 0", wave_cleared); end
    total++; if (wave_active !== 1'b0) begin bad++; $display("FAIL clear_inactive got %0b want 0", wave_active); end
  endtask

  task automatic test_reset();
    reset_fly = 1'b1; start = 1'b0; mode = 2'd0; kill_valid = 1'b0; kill_idx = '0;
    repeat (2) @(negedge clk25);
    total++; if (enemy_x !== '0 || enemy_y !== '0) begin bad++; $display("FAIL reset_pos got nonzero want 0"); end
    total++; if (enemy_alive !== '0) begin bad++; $display("FAIL reset_alive got %h want 0", enemy_alive); end
    total++; if ({wave_active, wave_cleared, kill_count, escape_count, wave_num} !== '0) begin
      bad++; $display("FAIL reset_status got %0b %0b %0d %0d %0d want all 0",
                      wave_active, wave_cleared, kill_count, escape_count, wave_num);
    end
    reset_fly = 1'b0;
    @(negedge clk25);
  endtask

  task automatic test_spawn();
    mode = 2'd0;
    spawn_wave();
    total++; if (enemy_alive !== 17'h1FFFF) begin bad++; $display("FAIL spawn_alive got %h want 1ffff", enemy_alive); end
    total++; if (ex(0) !== 10'd16) begin bad++; $display("FAIL spawn_x0 got %0d want 16", ex(0)); end
    total++; if (ex(16) !== 10'd624) begin bad++; $display("FAIL spawn_x16 got %0d want 624", ex(16)); end
    total++; if (ey(8) !== 10'd32) begin bad++; $display("FAIL spawn_y8 got %0d want 32", ey(8)); end
    total++; if (ey(16) !== 10'd0) begin bad++; $display("FAIL spawn_y16 got %0d want 0", ey(16)); end
    total++; if (ey(10) !== 10'd24) begin bad++; $display("FAIL spawn_y10 got %0d want 24", ey(10)); end
    total++; if (wave_num !== 8'd1) begin bad++; $display("FAIL spawn_wave_num got %0d want 1", wave_num); end
    total++; if (wave_active !== 1'b1) begin bad++; $display("FAIL spawn_active_run got %0b want 1", wave_active); end
  endtask

  task automatic test_straight();
    ticks(1);
    total++; if (ey(0) !== 10'd2 || ey(8) !== 10'd34) begin bad++; $display("FAIL straight_t1 got y0=%0d y8=%0d want 2 34", ey(0), ey(8)); end
    total++; if (ex(0) !== 10'd16) begin bad++; $display("FAIL straight_x_fixed got %0d want 16", ex(0)); end
    ticks(207);
    total++; if (ey(8) !== 10'd448 || enemy_alive !== 17'h1FFFF) begin
      bad++; $display("FAIL straight_t208 got y8=%0d alive=%h want 448 1ffff", ey(8), enemy_alive);
    end
    ticks(1);
    total++; if (enemy_alive !== 17'h1FEFF) begin bad++; $display("FAIL straight_first_escape got %h want 1feff", enemy_alive); end
    total++; if (escape_count !== 6'd1 || ey(8) !== 10'd448) begin
      bad++; $display("FAIL straight_escape_count got esc=%0d y8=%0d want 1 448", escape_count, ey(8));
    end
    wait_clear(6'd0, 6'd17);
    total++; if (ey(0) !== 10'd448) begin bad++; $display("FAIL straight_hold_pos got %0d want 448", ey(0)); end
  endtask

  task automatic test_zigzag();
    mode = 2'd1;
    spawn_wave();
    total++; if (wave_num !== 8'd2) begin bad++; $display("FAIL zig_wave_num got %0d want 2", wave_num); end
    ticks(1);
    total++; if (ex(0) !== 10'd18) begin bad++; $display("FAIL zig_t1 got %0d want 18", ex(0)); end
    ticks(7);
    total++; if (ex(0) !== 10'd32 || ex(16) !== 10'd640) begin bad++; $display("FAIL zig_t8 got %0d %0d want 32 640", ex(0), ex(16)); end
    ticks(1);
    total++; if (ex(0) !== 10'd30) begin bad++; $display("FAIL zig_t9_flip got %0d want 30", ex(0)); end
  endtask

  task automatic test_kill();
    kill_valid = 1'b1; kill_idx = 5'd3;
    @(negedge clk25);
    total++; if (enemy_alive[3] !== 1'b0 || kill_count !== 6'd1) begin
      bad++; $display("FAIL kill_idx3 got alive3=%0b kills=%0d want 0 1", enemy_alive[3], kill_count);
    end
    @(negedge clk25);
    total++; if (kill_count !== 6'd1) begin bad++; $display("FAIL kill_repeat got %0d want 1", kill_count); end
    kill_idx = 5'd20;
    @(negedge clk25);
    total++; if (kill_count !== 6'd1 || enemy_alive !== 17'h1FFF7) begin
      bad++; $display("FAIL kill_range got kills=%0d alive=%h want 1 1fff7", kill_count, enemy_alive);
    end
    kill_valid = 1'b0;
    @(negedge clk25);
    total++; if (ex(3) !== 10'd142 || ex(0) !== 10'd28) begin
      bad++; $display("FAIL zig_dead_shift got x3=%0d x0=%0d want 142 28", ex(3), ex(0));
    end
    ticks(14);
    total++; if (ex(0) !== 10'd0) begin bad++; $display("FAIL zig_t24 got %0d want 0", ex(0)); end
    ticks(1);
    total++; if (ex(0) !== 10'd2 || ey(8) !== 10'd82) begin bad++; $display("FAIL zig_t25 got x0=%0d y8=%0d want 2 82", ex(0), ey(8)); end
  endtask

  task automatic test_kill_escape();
    ticks(183);
    total++; if (ey(8) !== 10'd448) begin bad++; $display("FAIL ke_pre_y8 got %0d want 448", ey(8)); end
    repeat (3) @(negedge clk25);
    kill_valid = 1'b1; kill_idx = 5'd8;
    @(negedge clk25);
    kill_valid = 1'b0;
    total++; if (kill_count !== 6'd2 || escape_count !== 6'd0 || enemy_alive !== 17'h1FEF7) begin
      bad++; $display("FAIL kill_wins got kills=%0d esc=%0d alive=%h want 2 0 1fef7", kill_count, escape_count, enemy_alive);
    end
    ticks(1);
    repeat (3) @(negedge clk25);
    kill_valid = 1'b1; kill_idx = 5'd10;
    @(negedge clk25);
    kill_valid = 1'b0;
    total++; if (kill_count !== 6'd3 || escape_count !== 6'd2 || enemy_alive !== 17'h1F877) begin
      bad++; $display("FAIL kill_with_escapes got kills=%0d esc=%0d alive=%h want 3 2 1f877", kill_count, escape_count, enemy_alive);
    end
    wait_clear(6'd3, 6'd14);
  endtask

  task automatic test_idle_kill();
    kill_valid = 1'b1; kill_idx = 5'd0;
    @(negedge clk25);
    kill_valid = 1'b0;
    total++; if (kill_count !== 6'd3 || enemy_alive !== 17'h0) begin
      bad++; $display("FAIL idle_kill got kills=%0d alive=%h want 3 0", kill_count, enemy_alive);
    end
  endtask

  task automatic test_hold_and_reset();
    mode = 2'd2;
    spawn_wave();
    ticks(2);
    total++; if (ey(8) !== 10'd32 || ex(0) !== 10'd16) begin bad++; $display("FAIL hold_pos got y8=%0d x0=%0d want 32 16", ey(8), ex(0)); end
    start = 1'b1;
    @(negedge clk25);
    start = 1'b0;
    @(negedge clk25);
    total++; if (wave_num !== 8'd3 || wave_active !== 1'b1 || enemy_alive !== 17'h1FFFF) begin
      bad++; $display("FAIL start_in_run got wave=%0d active=%0b alive=%h want 3 1 1ffff", wave_num, wave_active, enemy_alive);
    end
    #2 reset_fly = 1'b1;
    #1;
    total++; if (enemy_x !== '0 || enemy_y !== '0 || enemy_alive !== '0) begin bad++; $display("FAIL async_reset_pos got nonzero want 0"); end
    total++; if (wave_num !== 8'd0 || wave_active !== 1'b0) begin
      bad++; $display("FAIL async_reset_status got wave=%0d active=%0b want 0 0", wave_num, wave_active);
    end
    @(negedge clk25);
    reset_fly = 1'b0;
    @(negedge clk25);
  endtask

  initial begin
    test_reset();
    test_spawn();
    test_straight();
    test_zigzag();
    test_kill();
    test_kill_escape();
    test_idle_kill();
    test_hold_and_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/enemy_wave_controller.md
Name: enemy_wave_controller

Overview:
Parametrised enemy-formation engine that spawns a wave of N enemies in a staggered V formation and advances it on a programmable movement tick. Supports straight-descent, zigzag and hold modes, external kill requests from the collision logic, and per-wave kill/escape accounting. Sits between the game-control FSM (start, mode) and the sprite renderer and collision unit (positions, alive mask).

Parameters:
N_ENEMY, 17, enemies per wave (1..32)
X_ORIGIN, 16, x of enemy 0 at spawn
X_SPACING, 38, x pitch between enemies
Y_STAGGER, 4, y step per index toward the V apex
TICK_PERIOD, 32768, clk25 cycles per movement tick (>=2)
DY, 2, y pixels per tick (descent)
ZIG_STEP, 2, x pixels per tick in zigzag mode
ZIG_AMP, 16, max abs x offset in zigzag (multiple of ZIG_STEP)
Y_LIMIT, 448, escape threshold (screen 480 minus sprite 32)

Ports:
clk25  in  1  system clock, 25 MHz
reset_fly  in  1  asynchronous, active-high reset
start  in  1  pulse; spawns a new wave when in IDLE
mode  in  2  0 straight, 1 zigzag, 2/3 hold; sampled on each tick
kill_valid  in  1  kill request strobe
kill_idx  in  5  enemy index to kill
enemy_x  out  10*N_ENEMY  flat x bus, enemy i at bits [10i+9:10i]
enemy_y  out  10*N_ENEMY  flat y bus, same packing
enemy_alive  out  N_ENEMY  alive mask
wave_active  out  1  high in SPAWN/RUN
wave_cleared  out  1  one-cycle pulse on wave end
kill_count  out  6  kills this wave
escape_count  out  6  escapes this wave
wave_num  out  8  waves spawned, wraps 255->0

Behaviour:
- Reset (async, reset_fly=1): state IDLE; all x/y=0; alive=0; counts, wave_num, tick counter, zig_off=0; zig_dir=right; wave_cleared=0.
- FSM IDLE->SPAWN on start; SPAWN->RUN unconditionally (1 cycle); RUN->DONE when alive mask==0; DONE->IDLE unconditionally, with wave_cleared=1 for that single cycle. start is ignored outside IDLE.
- SPAWN: x[i]=X_ORIGIN+i*X_SPACING; y[i]=i*Y_STAGGER for i<=(N_ENEMY-1)/2, else (N_ENEMY-1-i)*Y_STAGGER; alive all 1; kill/escape counts=0; zig_off=0, zig_dir=right; tick counter=0; wave_num+1.
- Tick: in RUN the counter runs 0..TICK_PERIOD-1; tick asserts in the cycle the counter equals TICK_PERIOD-1, then the counter wraps to 0. First tick occurs TICK_PERIOD cycles after entering RUN.
- On tick in mode 0 or 1, per alive enemy: if y>=Y_LIMIT then alive<=0 and escape (y unchanged); else y<=y+DY.
- Mode 1 on tick, additionally: nz=zig_off±ZIG_STEP per zig_dir. All x[i] (alive or not) shift by ±ZIG_STEP; zig_off<=nz; flip zig_dir when abs(nz)==ZIG_AMP.
- Modes 2/3: no position change; the tick counter still runs.
- escape_count increments by the number of enemies escaping in that tick (popcount), saturating at 63.
- Kill: kill_valid in RUN with kill_idx<N_ENEMY and alive[kill_idx]=1 clears alive next cycle and increments kill_count (saturating at 63). Otherwise the request is ignored with no count change.
- Kill and escape on the same enemy in the same cycle: kill wins and counts as a kill only. A kill on another enemy during a tick is counted alongside the escapes.
- Kill requests outside RUN are ignored.
- Positions and counts hold through DONE/IDLE until the next SPAWN. alive changes only in SPAWN, RUN, and reset.
- Reset mid-wave: immediate return to reset values, regardless of state.

Test Plan:
- Reset then start (N=17, TICK_PERIOD=4) -> cycle after SPAWN: alive=0x1FFFF, x[0]=16, x[16]=624, y[8]=32, y[16]=0, wave_num=1, wave_active=1.
- Mode 0, no kills, run to completion -> y advances by 2 every 4 cycles; enemy 8 escapes first; final escape_count=17, kill_count=0; single wave_cleared pulse; state returns to IDLE.
- Mode 1, ZIG_STEP=2, ZIG_AMP=16 -> x[0] goes 16,18..32 over 8 ticks, then 30..0, then back up; dead enemies' x also shift.
- kill_valid with idx 3 -> alive[3]=0, kill_count=1; repeat idx 3 -> no change; idx 20 -> ignored; kill during IDLE -> ignored.
- Kill enemy 8 on the tick where y[8]>=448 -> kill_count+1, escape_count unchanged.
- Assert reset_fly mid-RUN between clock edges -> outputs zero immediately; start pulse in RUN -> no respawn, wave_num unchanged.
